// File: rtl/float_cmp_pipe.sv
// Pipelined floating-point comparator with EQ/NE/LT/LE/GT/GE/UN/ORD operators.
// Define FLOAT_CMP_PIPE_FTZ_EN to flush subnormal operands to zero of the same sign.
module float_cmp_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [2:0]             op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   z,
  output logic                   unordered
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_EQ = 3'd0, OP_NE = 3'd1, OP_LT = 3'd2, OP_LE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4, OP_GE = 3'd5, OP_UN = 3'd6, OP_ORD = 3'd7;

  typedef struct packed {
    logic       un;
    logic       eq;
    logic       lt;
    logic [2:0] op;
  } cmp_t;

  function automatic logic cmp_res(input cmp_t c);
    logic r;
    r = 1'b0;
    case (c.op)
      OP_EQ:   r = c.eq & ~c.un;
      OP_NE:   r = ~c.eq | c.un;
      OP_LT:   r = c.lt & ~c.un;
      OP_LE:   r = (c.lt | c.eq) & ~c.un;
      OP_GT:   r = ~c.lt & ~c.eq & ~c.un;
      OP_GE:   r = ~c.lt & ~c.un;
      OP_UN:   r = c.un;
      OP_ORD:  r = ~c.un;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             sa, sb, nan_a, nan_b;
  logic [W-2:0]     ma, mb;
  cmp_t             cmp_in;

  // {exponent, mantissa} as an unsigned integer orders magnitudes, infinities included.
  always_comb begin
    sa    = a[W-1];
    sb    = b[W-1];
    ma    = a[W-2:0];
    mb    = b[W-2:0];
    nan_a = (&a[W-2:MAN_W]) & (|a[MAN_W-1:0]);
    nan_b = (&b[W-2:MAN_W]) & (|b[MAN_W-1:0]);
`ifdef FLOAT_CMP_PIPE_FTZ_EN
    if (a[W-2:MAN_W] == '0) ma = '0;
    if (b[W-2:MAN_W] == '0) mb = '0;
`else
`endif
    cmp_in    = '0;
    cmp_in.un = nan_a | nan_b;
    cmp_in.eq = ((ma == '0) && (mb == '0)) || ((sa == sb) && (ma == mb));
    if (sa != sb)  cmp_in.lt = sa & ~cmp_in.eq;
    else if (sa)   cmp_in.lt = ma > mb;
    else           cmp_in.lt = ma < mb;
    cmp_in.op = op;
  end

  logic               en;
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic               z_q, z_d, un_q, un_d;

  assign en        = ~vld_pipe_q[LATENCY-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe_q[LATENCY-1];
  assign z         = z_q;
  assign unordered = un_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (en) vld_pipe_d = (vld_pipe_q << 1) | LATENCY'(in_valid);
  end

  generate
    if (LATENCY == 1) begin : g_single
      always_comb begin
        z_d  = z_q;
        un_d = un_q;
        if (en) begin
          z_d  = cmp_res(cmp_in);
          un_d = cmp_in.un;
        end
      end
    end else begin : g_multi
      // Stage 1 holds the raw compare; middle stages only delay it; last stage resolves op.
      cmp_t [LATENCY-2:0] cmp_q, cmp_d;

      always_comb begin
        cmp_d = cmp_q;
        z_d   = z_q;
        un_d  = un_q;
        if (en) begin
          cmp_d[0] = cmp_in;
          for (int i = 1; i < LATENCY-1; i++) cmp_d[i] = cmp_q[i-1];
          z_d  = cmp_res(cmp_q[LATENCY-2]);
          un_d = cmp_q[LATENCY-2].un;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cmp_q <= '0;
        else     cmp_q <= cmp_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      z_q        <= 1'b0;
      un_q       <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      z_q        <= z_d;
      un_q       <= un_d;
    end
  end
endmodule

// File: tb/tb_float_cmp_pipe.sv
// Self-checking bench for float_cmp_pipe: a single-precision LATENCY=2 instance
// and a 16-bit LATENCY=4 instance, checked against a value-ordering reference model.
`timescale 1ns/1ps
module tb_float_cmp_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        v0, r0, ov0, ordy0, z0, u0;
  logic [31:0] a0, b0;
  logic [2:0]  op0;
  logic        v1, r1, ov1, ordy1, z1, u1;
  logic [15:0] a1, b1;
  logic [2:0]  op1;

  float_cmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0), .op(op0),
    .out_valid(ov0), .out_ready(ordy0), .z(z0), .unordered(u0));

  float_cmp_pipe #(.EXP_W(5), .MAN_W(10), .LATENCY(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(ordy1), .z(z1), .unordered(u1));

  function automatic longint key_of(input logic [31:0] x, input int ew, input int mw);
    longint e, m, mag;
    e = longint'(x >> mw) & ((longint'(1) << ew) - 1);
    m = longint'(x) & ((longint'(1) << mw) - 1);
`ifdef FLOAT_CMP_PIPE_FTZ_EN
    if (e == 0) m = 0;
`endif
    mag = e * (longint'(1) << mw) + m;
    return x[ew+mw] ? -mag : mag;
  endfunction

  function automatic logic is_nan(input logic [31:0] x, input int ew, input int mw);
    longint e, m;
    e = longint'(x >> mw) & ((longint'(1) << ew) - 1);
    m = longint'(x) & ((longint'(1) << mw) - 1);
    return (e == (longint'(1) << ew) - 1) && (m != 0);
  endfunction

  task automatic ref_cmp(input logic [31:0] a, input logic [31:0] b, input int ew, input int mw,
                         input logic [2:0] op, output logic z, output logic un);
    longint ka, kb;
    ka = key_of(a, ew, mw);
    kb = key_of(b, ew, mw);
    un = is_nan(a, ew, mw) || is_nan(b, ew, mw);
    case (op)
      3'd0: z = !un && (ka == kb);
      3'd1: z = un || (ka != kb);
      3'd2: z = !un && (ka <  kb);
      3'd3: z = !un && (ka <= kb);
      3'd4: z = !un && (ka >  kb);
      3'd5: z = !un && (ka >= kb);
      3'd6: z = un;
      default: z = !un;
    endcase
  endtask

  function automatic logic [31:0] rnd_op(input int ew, input int mw);
    logic [31:0] x, emask, mmask;
    int k;
    x     = $urandom;
    emask = ((32'd1 << ew) - 1) << mw;
    mmask = (32'd1 << mw) - 1;
    k     = $urandom_range(0, 5);
    if (k == 0)      x = x & ~emask;
    else if (k == 1) x = x | emask;
    if ($urandom_range(0, 2) == 0) x = x & ~mmask;
    return x & ((32'd1 << (1 + ew + mw)) - 1);
  endfunction

  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      output int lat, output logic z, output logic u);
    if (d == 0) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    else begin v1 = 1'b1; a1 = a[15:0]; b1 = b[15:0]; op1 = op; end
    @(posedge clk); #1;
    v0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 3'($urandom);
    v1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); op1 = 3'($urandom);
    lat = 1;
    while (((d == 0) ? ov0 : ov1) !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z = (d == 0) ? z0 : z1;
    u = (d == 0) ? u0 : u1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #20;
    n_tests++;
    if (ov0 !== 1'b0 || z0 !== 1'b0 || u0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: ov=%b z=%b u=%b rdy=%b, expected 0 0 0 1", ov0, z0, u0, r0);
    end
    n_tests++;
    if (ov1 !== 1'b0 || r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state_p: ov=%b rdy=%b, expected 0 1", ov1, r1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ov0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: ov=%b rdy=%b, expected 0 1", ov0, r0);
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        z, u;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    int lat;
    logic z, u, ftz_z;
`ifdef FLOAT_CMP_PIPE_FTZ_EN
    ftz_z = 1'b0;
`else
    ftz_z = 1'b1;
`endif
    tbl.push_back('{32'h40000000, 32'h3F800000, 3'd4, 1'b1, 1'b0});
    tbl.push_back('{32'h40000000, 32'h3F800000, 3'd2, 1'b0, 1'b0});
    tbl.push_back('{32'h00000000, 32'h80000000, 3'd0, 1'b1, 1'b0});
    tbl.push_back('{32'h00000000, 32'h80000000, 3'd2, 1'b0, 1'b0});
    tbl.push_back('{32'h00000000, 32'h80000000, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{32'hBF800000, 32'h3F800000, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{32'hFF800000, 32'hFF7FFFFF, 3'd2, 1'b1, 1'b0});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 3'd1, 1'b1, 1'b1});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 3'd5, 1'b0, 1'b1});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 3'd6, 1'b1, 1'b1});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 3'd7, 1'b0, 1'b1});
    tbl.push_back('{32'h00000001, 32'h00000000, 3'd4, ftz_z, 1'b0});
    foreach (tbl[i]) begin
      send(0, tbl[i].a, tbl[i].b, tbl[i].op, lat, z, u);
      n_tests++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d, expected 2", i, lat);
      end
      n_tests++;
      if (z !== tbl[i].z || u !== tbl[i].u) begin
        n_fail++;
        $display("FAIL dir%0d_result: got z=%b u=%b, expected z=%b u=%b", i, z, u, tbl[i].z, tbl[i].u);
      end
    end
  endtask

  task automatic test_random_single();
    int lat, ew, mw, el;
    logic z, u, ez, eu;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    for (int i = 0; i < 40; i++) begin
      if (i < 30) begin ew = 8; mw = 23; el = 2; end
      else begin ew = 5; mw = 10; el = 4; end
      ra  = rnd_op(ew, mw);
      rb  = rnd_op(ew, mw);
      if ($urandom_range(0, 3) == 0) rb = ra ^ (32'd1 << (ew + mw));
      rop = 3'($urandom);
      ref_cmp(ra, rb, ew, mw, rop, ez, eu);
      send((i < 30) ? 0 : 1, ra, rb, rop, lat, z, u);
      n_tests++;
      if (lat != el || z !== ez || u !== eu) begin
        n_fail++;
        $display("FAIL rand%0d: a=%h b=%h op=%0d got lat=%0d z=%b u=%b, expected lat=%0d z=%b u=%b",
                 i, ra, rb, rop, lat, z, u, el, ez, eu);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_z[$], exp_u[$];
    int sent = 0, got = 0, stall_left = 0, stalls_seen = 0;
    logic ez, eu;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      ordy0 = (stall_left > 0) ? 1'b0 : 1'b1;
      #1;
      if (ov0 === 1'b1 && !ordy0) begin
        stalls_seen++;
        n_tests++;
        if (r0 !== 1'b0 || z0 !== exp_z[0] || u0 !== exp_u[0]) begin
          n_fail++;
          $display("FAIL b2b_stall: rdy=%b z=%b u=%b, expected rdy=0 z=%b u=%b", r0, z0, u0, exp_z[0], exp_u[0]);
        end
      end else if (ov0 === 1'b1) begin
        n_tests++;
        if (exp_z.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got unexpected result z=%b, expected none", z0);
        end else begin
          if (z0 !== exp_z[0] || u0 !== exp_u[0]) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got z=%b u=%b, expected z=%b u=%b", got, z0, u0, exp_z[0], exp_u[0]);
          end
          void'(exp_z.pop_front());
          void'(exp_u.pop_front());
        end
        got++;
        if (got == 1) stall_left = 4;
      end
      if (sent < 6) begin
        ra = rnd_op(8, 23); rb = rnd_op(8, 23); rop = 3'($urandom);
        v0 = 1'b1; a0 = ra; b0 = rb; op0 = rop;
        if (r0 === 1'b1) begin
          ref_cmp(ra, rb, 8, 23, rop, ez, eu);
          exp_z.push_back(ez);
          exp_u.push_back(eu);
          sent++;
        end
      end else v0 = 1'b0;
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
    end
    v0 = 1'b0;
    ordy0 = 1'b1;
    n_tests++;
    if (got != 6 || stalls_seen != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results %0d stall cycles, expected 6 and 3", got, stalls_seen);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid=%b, expected 0", ov0);
    end
  endtask

  task automatic test_param_stream();
    logic exp_z[$], exp_u[$];
    int sent = 0, got = 0;
    logic ez, eu;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      ordy1 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov1 === 1'b1 && !ordy1) begin
        n_tests++;
        if (r1 !== 1'b0 || exp_z.size() == 0 || z1 !== exp_z[0] || u1 !== exp_u[0]) begin
          n_fail++;
          $display("FAIL p_stall: rdy=%b z=%b u=%b, expected rdy=0 and held scoreboard head", r1, z1, u1);
        end
      end else if (ov1 === 1'b1) begin
        n_tests++;
        if (exp_z.size() == 0) begin
          n_fail++;
          $display("FAIL p_extra: got unexpected result z=%b, expected none", z1);
        end else begin
          if (z1 !== exp_z[0] || u1 !== exp_u[0]) begin
            n_fail++;
            $display("FAIL p_result%0d: got z=%b u=%b, expected z=%b u=%b", got, z1, u1, exp_z[0], exp_u[0]);
          end
          void'(exp_z.pop_front());
          void'(exp_u.pop_front());
        end
        got++;
      end
      if (sent < 20 && $urandom_range(0, 4) != 0) begin
        ra = rnd_op(5, 10); rb = rnd_op(5, 10); rop = 3'($urandom);
        if ($urandom_range(0, 4) == 0) rb = ra;
        v1 = 1'b1; a1 = ra[15:0]; b1 = rb[15:0]; op1 = rop;
        if (r1 === 1'b1) begin
          ref_cmp(ra, rb, 5, 10, rop, ez, eu);
          exp_z.push_back(ez);
          exp_u.push_back(eu);
          sent++;
        end
      end else v1 = 1'b0;
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    ordy1 = 1'b1;
    n_tests++;
    if (got != 20) begin
      n_fail++;
      $display("FAIL p_count: got %0d results, expected 20", got);
    end
  endtask

  task automatic test_reset_midstream();
    int lat;
    logic z, u, stale;
    ordy0 = 1'b1;
    v0 = 1'b1; a0 = 32'h40000000; b0 = 32'h3F800000; op0 = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #2;
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (ov0 !== 1'b0 || z0 !== 1'b0 || u0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: ov=%b z=%b u=%b, expected 0 0 0", ov0, z0, u0);
    end
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ov0 !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL rst_stale: saw out_valid=1, expected 0 after reset");
    end
    send(0, 32'hBF800000, 32'h3F800000, 3'd2, lat, z, u);
    n_tests++;
    if (lat != 2 || z !== 1'b1 || u !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_recover: got lat=%0d z=%b u=%b, expected lat=2 z=1 u=0", lat, z, u);
    end
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; ordy0 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; ordy1 = 1'b1;
    test_reset();
    test_directed();
    test_random_single();
    test_back_to_back();
    test_param_stream();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/float_cmp_pipe.md
# float_cmp_pipe

Parametrised, pipelined IEEE-754-style floating-point comparator with a valid/ready handshake. It generalises the fixed single-precision greater-than comparator in three ways: configurable exponent and mantissa widths, a run-time selectable comparison operator, and an explicit unordered (NaN) flag. It sits between operand-issue logic and the condition/branch or select units of the float datapath.

## Interface
- EXP_W, 8, exponent field width (≥2)
- MAN_W, 23, stored mantissa field width (≥1); total operand width W = 1+EXP_W+MAN_W
- LATENCY, 2, number of register stages from accepted input to out_valid (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair and op present
- in_ready  out  1  block can accept this cycle
- a  in  W  left operand {sign, exponent, mantissa}
- b  in  W  right operand
- op  in  3  operator: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN, 7 ORD (meaning a op b)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- z  out  1  comparison result
- unordered  out  1  at least one operand is NaN

## Operation
- Classification per operand: NaN = exponent all ones and mantissa ≠0; zero = exponent 0 and mantissa 0; subnormal = exponent 0 and mantissa ≠0; infinity = exponent all ones and mantissa 0.
- Ordering uses sign-magnitude integer order on {exponent, mantissa}. Positive operands: the larger magnitude is greater. Negative operands: the larger magnitude is smaller. Opposite signs: the positive operand is greater, except +0 == −0.
- Infinities order naturally: −inf < any finite value < +inf.
- Subnormals are fully ordered below the smallest normal value.
- Unordered case (either operand is NaN):
  - EQ, LT, LE, GT and GE return 0.
  - NE returns 1.
  - UN returns 1 and ORD returns 0.
  - unordered is asserted to 1.
- Ordered case: UN returns 0 and ORD returns 1.
- Stage 1 registers the classification, the sign/magnitude compare (eq, lt) and op. The final stage registers z and unordered. Any extra stages (LATENCY>2) are pass-through registers. For LATENCY=1 all logic feeds a single register.
- Each stage holds a valid bit. Bubbles are carried, not collapsed.

## Timing
- Global-enable pipeline:
  - en = ~out_valid | out_ready.
  - in_ready = en, combinational.
  - When en=1 all stages shift, and stage 1 valid loads in_valid.
  - When en=0 every stage, including z and unordered, holds.
- A transfer occurs on a rising edge with in_valid & in_ready. Its result appears with out_valid=1 exactly LATENCY cycles later, provided en stayed 1 throughout.
- Each cycle of en=0 adds exactly one cycle of delay.
- Back-to-back transfers sustain one result per cycle while out_ready=1.
- When out_valid=1 and out_ready=0, z and unordered are stable until the handshake completes.
- Results leave in input order, with no loss or duplication.
- Reset values: all stage valid bits 0, out_valid 0, z 0, unordered 0, internal data registers 0.
- in_ready is 1 while out_valid=0, including immediately after reset.
- Reset asserted mid-stream clears the pipeline asynchronously. In-flight operations are discarded and never produce output.
- The first transfer is the first rising edge with rst low and in_valid & in_ready.
- op, a and b are sampled only on a transfer edge. Their values at other times are ignored.

## Configuration
- FLOAT_CMP_PIPE_FTZ_EN defined:
  - Subnormal operands are treated as zero of the same sign before comparison. The ±0 equality rule then applies.
  - NaN and infinity handling is unchanged.
- Not defined: subnormals are compared at full precision, as described under Operation.
- Latency and handshake behaviour are identical in both builds.

## Test plan
- Default params, LATENCY=2: a=0x40000000 (2.0), b=0x3F800000 (1.0), op=GT, out_ready=1 → out_valid=1 two cycles after transfer, z=1, unordered=0. Same operands with op=LT → z=0.
- a=0x00000000, b=0x80000000 → op=EQ gives z=1, op=LT gives z=0, op=GE gives z=1. a=0xBF800000 (−1.0), b=0x3F800000 with op=LT → z=1. a=0xFF800000 (−inf), b=0xFF7FFFFF (most negative finite) with op=LT → z=1.
- a=0x7FC00000 (NaN), b=0x3F800000 → op=NE gives z=1, op=GE gives z=0, op=UN gives z=1, op=ORD gives z=0, all with unordered=1.
- a=0x00000001, b=0x00000000, op=GT → z=1 without FTZ, z=0 with FLOAT_CMP_PIPE_FTZ_EN.
- Stream 6 pairs back-to-back, drop out_ready for 3 cycles after the first result → in_ready=0 and z held during the stall. All 6 results arrive in order, one each, and each matches the scoreboard. Repeat with EXP_W=5, MAN_W=10, LATENCY=4 using random operands against a reference model.
- Assert rst while 2 operations are in flight → out_valid=0 and z=0 immediately, without waiting for a clock. After release, no stale result appears and the next transfer completes with the normal latency.
